// File: rtl/br_resolve_unit.sv
// rtl/br_resolve_unit.sv - ID-stage branch resolver with PC-indexed 2-bit predictor table
//
// Resolves beq/bne/blez/bgtz/bltz/bgez on forwarded operands and compares the
// outcome against a table of 2-bit saturating counters indexed by pc[IDX+1:2].
// Optional statistics counters are enabled by defining BR_STATS_EN.
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous active-high reset
//   instr         ID-stage instruction word
//   pc            ID-stage PC
//   valid         ID stage holds a real instruction
//   stall         ID stage frozen; suppresses table update and mispredict_q
//   rdata1/2      forwarded rs/rt values
//   is_branch     instr is a supported conditional branch
//   br_taken      resolved branch outcome (combinational)
//   pred_taken    table prediction for pc (combinational)
//   mispredict    valid & is_branch & (br_taken != pred_taken)
//   mispredict_q  registered mispredict, one pulse per resolved branch
//   br_count      (BR_STATS_EN) table-update events, saturating
//   mis_count     (BR_STATS_EN) mispredicted update events, saturating

module br_resolve_unit #(
    parameter int WIDTH     = 32,
    parameter int BHT_DEPTH = 16,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instr,
    input  logic [31:0]      pc,
    input  logic             valid,
    input  logic             stall,
    input  logic [WIDTH-1:0] rdata1,
    input  logic [WIDTH-1:0] rdata2,
    output logic             is_branch,
    output logic             br_taken,
    output logic             pred_taken,
    output logic             mispredict,
    output logic             mispredict_q
`ifdef BR_STATS_EN
    ,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mis_count
`endif
);

    localparam int IDX = $clog2(BHT_DEPTH);

    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;

    logic [5:0]     opcode;
    logic [4:0]     rt_field;
    logic           r1_zero;
    logic           r1_neg;
    logic           r_eq;
    logic [IDX-1:0] idx;
    logic [1:0]     bht [BHT_DEPTH];
    logic [1:0]     cur_cnt;
    logic [1:0]     nxt_cnt;
    logic           upd;

    // Fields of instr/pc that play no part in resolution or indexing.
    logic unused_bits;
    assign unused_bits = ^{instr[25:21], instr[15:0], pc[31:IDX+2], pc[1:0]};

    assign opcode   = instr[31:26];
    assign rt_field = instr[20:16];
    assign r1_zero  = (rdata1 == '0);
    assign r1_neg   = rdata1[WIDTH-1];
    assign r_eq     = (rdata1 == rdata2);

    always_comb begin
        is_branch = 1'b0;
        br_taken  = 1'b0;
        case (opcode)
            OP_BEQ: begin
                is_branch = 1'b1;
                br_taken  = r_eq;
            end
            OP_BNE: begin
                is_branch = 1'b1;
                br_taken  = !r_eq;
            end
            OP_BLEZ: begin
                is_branch = 1'b1;
                br_taken  = r1_neg | r1_zero;
            end
            OP_BGTZ: begin
                is_branch = 1'b1;
                br_taken  = !r1_neg & !r1_zero;
            end
            OP_REGIMM: begin
                // Only bltz (rt=0) and bgez (rt=1) are handled; other REGIMM
                // encodings (e.g. bltzal) are treated as non-branches.
                if (rt_field == 5'b00000) begin
                    is_branch = 1'b1;
                    br_taken  = r1_neg;
                end else if (rt_field == 5'b00001) begin
                    is_branch = 1'b1;
                    br_taken  = !r1_neg;
                end
            end
            default: ;
        endcase
    end

    assign idx        = pc[IDX+1:2];
    assign cur_cnt    = bht[idx];
    assign pred_taken = is_branch & cur_cnt[1];
    assign mispredict = valid & is_branch & (br_taken ^ pred_taken);
    assign upd        = valid & is_branch & !stall;

    always_comb begin
        nxt_cnt = cur_cnt;
        if (br_taken) begin
            if (cur_cnt != 2'b11) nxt_cnt = cur_cnt + 2'd1;
        end else begin
            if (cur_cnt != 2'b00) nxt_cnt = cur_cnt - 2'd1;
        end
    end

    // pred_taken reads the table combinationally, so a same-cycle lookup sees
    // the pre-update counter; the write lands at the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht[i] <= 2'b01;
            end
            mispredict_q <= 1'b0;
        end else begin
            mispredict_q <= mispredict & !stall;
            if (upd) begin
                bht[idx] <= nxt_cnt;
            end
        end
    end

`ifdef BR_STATS_EN
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            br_count  <= '0;
            mis_count <= '0;
        end else if (upd) begin
            if (br_count != '1) br_count <= br_count + CNT_ONE;
            if (mispredict && (mis_count != '1)) mis_count <= mis_count + CNT_ONE;
        end
    end
`endif

endmodule
